// File: rtl/f1_pkg.sv
// f1_light_sequencer shared types and constants.
// Optional build macro: F1_JUMP_START_EN.
package f1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LIGHTS,
    HOLD,
    GO,
    DONE
  } state_t;

  // x^7 + x^6 + 1
  localparam logic [6:0] LFSR_TAPS = 7'b110_0000;

  localparam logic [63:0] JUMP_START_CODE = '1;

endpackage

// File: rtl/f1_light_sequencer_if.sv
// f1_light_sequencer switch/button and lamp/display bundle.
// Optional build macro: F1_JUMP_START_EN.
interface f1_light_sequencer_if #(
  parameter int N_WIDTH = 16,
  parameter int D_WIDTH = 8,
  parameter int R_WIDTH = 16
);

  logic               en;
  logic [N_WIDTH-1:0] N;
  logic               trigger;
  logic               stop;
  logic [D_WIDTH-1:0] lights;
  logic               go;
  logic               busy;
  logic [R_WIDTH-1:0] react_time;
  logic               react_valid;

  modport master (
    output en, N, trigger, stop,
    input  lights, go, busy,
    input  react_time, react_valid
  );

  modport slave (
    input  en, N, trigger, stop,
    output lights, go, busy,
    output react_time, react_valid
  );

endinterface

// File: rtl/f1_light_sequencer_tick_gen.sv
// N+1 tick divider for f1_light_sequencer.
// Optional build macro: F1_JUMP_START_EN (not used here).
module tick_gen #(
  parameter int N_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               reload,
  input  logic [N_WIDTH-1:0] n,
  output logic               tick
);

  logic [N_WIDTH-1:0] count;

  // tick only ever follows an enabled cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= n;
      tick  <= 1'b0;
    end else if (reload) begin
      count <= n;
      tick  <= 1'b0;
    end else if (en) begin
      if (count == '0) begin
        count <= n;
        tick  <= 1'b1;
      end else begin
        count <= count - 1'b1;
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/f1_light_sequencer.sv
// F1 start-light game controller: lamp sequence, random hold, reaction timer.
// Optional build macro: F1_JUMP_START_EN (stop during LIGHTS/HOLD is a jump start).
module f1_light_sequencer
  import f1_pkg::*;
#(
  parameter int N_WIDTH    = 16,
  parameter int D_WIDTH    = 8,
  parameter int LFSR_WIDTH = 7,
  parameter int R_WIDTH    = 16
) (
  input logic                 clk,
  input logic                 rst,
  f1_light_sequencer_if.slave io
);

`ifdef F1_JUMP_START_EN
  localparam bit JUMP = 1'b1;
`else
  localparam bit JUMP = 1'b0;
`endif

  localparam logic [LFSR_WIDTH-1:0] TAPS =
    LFSR_WIDTH'(LFSR_TAPS);
  localparam logic [R_WIDTH-1:0] JS_CODE =
    JUMP_START_CODE[R_WIDTH-1:0];

  state_t                state, state_n;
  logic [D_WIDTH-1:0]    lights_q, lights_n;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic [LFSR_WIDTH-1:0] delay, delay_n;
  logic [R_WIDTH-1:0]    rcnt, rcnt_n, rinc;
  logic [R_WIDTH-1:0]    react_q, react_n;
  logic                  valid_q, valid_n;
  logic                  reload, tick;

  assign reload = ((state == IDLE) || (state == DONE))
                  && io.trigger;

  tick_gen #(.N_WIDTH(N_WIDTH)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (io.en),
    .reload (reload),
    .n      (io.N),
    .tick   (tick)
  );

  assign rinc = (tick && (rcnt != '1)) ? rcnt + 1'b1 : rcnt;

  always_comb begin
    state_n  = state;
    lights_n = lights_q;
    delay_n  = delay;
    rcnt_n   = rcnt;
    react_n  = react_q;
    valid_n  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (io.trigger) begin
          state_n  = LIGHTS;
          lights_n = '0;
        end
      end
      LIGHTS: begin
        if (JUMP && io.stop) begin
          state_n  = DONE;
          lights_n = '0;
          react_n  = JS_CODE;
          valid_n  = 1'b1;
        end else if (tick) begin
          if (&lights_q) begin
            state_n = HOLD;
            delay_n = lfsr;
          end else begin
            lights_n = {lights_q[D_WIDTH-2:0], 1'b1};
          end
        end
      end
      HOLD: begin
        if (JUMP && io.stop) begin
          state_n  = DONE;
          lights_n = '0;
          react_n  = JS_CODE;
          valid_n  = 1'b1;
        end else if (tick) begin
          if (delay == LFSR_WIDTH'(1)) begin
            state_n  = GO;
            lights_n = '0;
            rcnt_n   = '0;
          end else begin
            delay_n = delay - 1'b1;
          end
        end
      end
      GO: begin
        // a tick landing with stop is still counted
        if (io.stop) begin
          state_n = DONE;
          react_n = rinc;
          valid_n = 1'b1;
        end else begin
          rcnt_n = rinc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      lights_q <= '0;
      delay    <= '0;
      rcnt     <= '0;
      react_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_n;
      lights_q <= lights_n;
      delay    <= delay_n;
      rcnt     <= rcnt_n;
      react_q  <= react_n;
      valid_q  <= valid_n;
    end
  end

  // free-running, independent of en and state
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr <= LFSR_WIDTH'(1);
    end else begin
      lfsr <= {lfsr[LFSR_WIDTH-2:0], ^(lfsr & TAPS)};
    end
  end

  assign io.lights      = lights_q;
  assign io.go          = (state == GO);
  assign io.busy        = (state == LIGHTS) ||
                          (state == HOLD) ||
                          (state == GO);
  assign io.react_time  = react_q;
  assign io.react_valid = valid_q;

endmodule

// File: tb/tb_f1_light_sequencer.sv
// Scoreboard bench for f1_light_sequencer against a tick-timeline model.
// Optional build macro: F1_JUMP_START_EN.
module tb_f1_light_sequencer;

  localparam int NW = 16;
  localparam int DW = 8;
  localparam int LW = 7;
  localparam int RW = 16;

`ifdef F1_JUMP_START_EN
  localparam bit JUMP_ON = 1'b1;
`else
  localparam bit JUMP_ON = 1'b0;
`endif

  typedef struct {
    int          at;
    logic [7:0]  lights;
    logic        go;
    logic        busy;
    logic [15:0] rt;
    logic        rv;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  f1_light_sequencer_if #(
    .N_WIDTH(NW), .D_WIDTH(DW), .R_WIDTH(RW)
  ) bus ();

  f1_light_sequencer #(
    .N_WIDTH(NW), .D_WIDTH(DW),
    .LFSR_WIDTH(LW), .R_WIDTH(RW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  ev_t q[$];
  ev_t me;
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;
  bit  mon_on = 1'b0;
  int  rlast  = 0;
  int  last_rt = 0;
  int  seq[127];

  logic [7:0]  pl  = '0;
  logic        pg  = 1'b0;
  logic        pb  = 1'b0;
  logic [15:0] prt = '0;

  always @(posedge clk) cyc++;

  function automatic void push(int at, int l, bit g, bit b,
                               int rt, bit rv);
    ev_t e;
    e.at = at;
    e.lights = l[7:0];
    e.go = g;
    e.busy = b;
    e.rt = rt[15:0];
    e.rv = rv;
    q.push_back(e);
  endfunction

  function automatic bit en_of(int e, int gs, int gl);
    return !(gl > 0 && e >= gs && e < gs + gl);
  endfunction

  // monitor: any visible output change must match the next expectation
  always @(negedge clk) begin
    if (mon_on) begin
      while (q.size() > 0 && q[0].at < cyc) begin
        me = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event at=%0d lights=%h go=%b rt=%h now=%0d",
                 me.at, me.lights, me.go, me.rt, cyc);
      end
      if (bus.lights !== pl || bus.go !== pg ||
          bus.busy !== pb || bus.react_time !== prt ||
          bus.react_valid !== 1'b0) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d lights=%h go=%b busy=%b rt=%h rv=%b",
                   cyc, bus.lights, bus.go, bus.busy,
                   bus.react_time, bus.react_valid);
        end else begin
          me = q.pop_front();
          if (me.at != cyc || bus.lights !== me.lights ||
              bus.go !== me.go || bus.busy !== me.busy ||
              bus.react_time !== me.rt ||
              bus.react_valid !== me.rv) begin
            errors++;
            $display("FAIL event got cyc=%0d lights=%h go=%b busy=%b rt=%h rv=%b want cyc=%0d lights=%h go=%b busy=%b rt=%h rv=%b",
                     cyc, bus.lights, bus.go, bus.busy,
                     bus.react_time, bus.react_valid,
                     me.at, me.lights, me.go, me.busy,
                     me.rt, me.rv);
          end
        end
      end
      pl  = bus.lights;
      pg  = bus.go;
      pb  = bus.busy;
      prt = bus.react_time;
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // model the game as a tick timeline, then play it
  task automatic play(input int n, input int gs, input int gl,
                      input int k, input bit jump, input bit abrt,
                      input bit trg_stop, input int spur);
    int T, ec, lit, ph, d, ht, rc;
    int xrel, jrel, arel, endrel;
    bit t, step, done;
    T = cyc + 1;
    push(T, 0, 0, 1, last_rt, 0);
    ec = 0; t = 0; lit = 0; ph = 0; d = 0; ht = 0; rc = 0;
    xrel = -1; jrel = -1; arel = -1; endrel = 0; done = 0;
    for (int e = 1; e < 4000 && !done; e++) begin
      step = t;
      if (en_of(e, gs, gl)) begin
        ec++;
        t = (ec % (n + 1) == 0);
      end else begin
        t = 0;
      end
      if (e == arel) begin
        push(T + e, 0, 0, 0, 0, 0);
        last_rt = 0; endrel = e; done = 1;
      end else if (e == jrel && JUMP_ON) begin
        push(T + e, 0, 0, 0, 16'hffff, 1);
        last_rt = 16'hffff; endrel = e; done = 1;
      end else if (e == xrel) begin
        if (step && rc < 65535) rc++;
        push(T + e, 0, 0, 0, rc, 1);
        last_rt = rc; endrel = e; done = 1;
      end else if (step) begin
        if (ph == 0) begin
          if (lit < 8) begin
            lit++;
            push(T + e, (1 << lit) - 1, 0, 1, last_rt, 0);
            if (abrt && lit == 3) arel = e + 1;
          end else begin
            ph = 1;
            d = seq[(T + e - 1 - rlast) % 127];
            if (jump) jrel = e + 1;
          end
        end else if (ph == 1) begin
          ht++;
          if (ht == d) begin
            ph = 2;
            push(T + e, 0, 1, 1, last_rt, 0);
            xrel = e + k;
          end
        end else if (rc < 65535) begin
          rc++;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL model_timeout n=%0d", n);
      return;
    end
    for (int r = 0; r <= endrel; r++) begin
      bus.N       = NW'(n);
      bus.en      = en_of(r, gs, gl);
      bus.trigger = (r == 0) || (r == spur) ||
                    (trg_stop && r == xrel);
      bus.stop    = (r == xrel) || (r == jrel);
      rst         = !(abrt && r == arel);
      @(posedge clk); #1;
    end
    if (abrt) begin
      rst = 1'b0;
      @(posedge clk); #1;
      rlast = cyc;
      rst = 1'b1;
    end
    bus.trigger = 1'b0;
    bus.stop    = 1'b1;
    bus.en      = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    int v;
    v = 1;
    for (int i = 0; i < 127; i++) begin
      seq[i] = v;
      v = ((v << 1) & 8'h7f) | (((v >> 6) ^ (v >> 5)) & 1);
    end
    rst = 1'b0;
    bus.en = 1'b1;
    bus.N = NW'(3);
    bus.trigger = 1'b0;
    bus.stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rlast = cyc;
    chk("rst_lights", int'(bus.lights), 0);
    chk("rst_go", int'(bus.go), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_react_time", int'(bus.react_time), 0);
    chk("rst_react_valid", int'(bus.react_valid), 0);
    rst = 1'b1;
    mon_on = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("idle_lights", int'(bus.lights), 0);
    // directed: sequence, reaction 37 at N=0, en gap, jump, abort
    play(3, 1, 0, 20, 0, 0, 0, -1);
    play(0, 1, 0, 37, 0, 0, 0, -1);
    play(3, 10, 10, 12, 0, 0, 0, -1);
    play(3, 1, 0, 9, 1, 0, 0, -1);
    play(2, 1, 0, 5, 0, 1, 0, -1);
    play(1, 1, 0, 7, 0, 0, 1, 4);
    play(0, 3, 10, 1, 0, 0, 0, 2);
    for (int g = 0; g < 8; g++) begin
      play($urandom_range(3, 0), $urandom_range(30, 1),
           $urandom_range(10, 0), $urandom_range(60, 1),
           1'($urandom_range(1, 0)), 1'b0,
           1'($urandom_range(1, 0)), $urandom_range(6, 1));
    end
    repeat (10) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
